// File: rtl/rat_intc_pkg.sv
// Shared types and helpers for the RAT MCU interrupt controller.
// Holds the FSM state type, default port IDs and the priority-index helper.
package rat_intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLDOFF  = 2'd3
  } intc_state_e;

  localparam logic [7:0] MASK_ID_DEF = 8'h30;
  localparam logic [7:0] PEND_ID_DEF = 8'h31;
  localparam logic [7:0] VEC_ID_DEF  = 8'h32;

  // Lowest set bit wins, so source 0 has the highest priority; 0 when empty.
  function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
    lowest_set_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/rat_irq_edge_sync.sv
// One IRQ source: 2-flop synchronizer, prev flop and a registered rise pulse.
// An input already high when reset releases produces a single rise.
module rat_irq_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // which is what turns these four statements into a shift chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller driving the RAT MCU INTR pin from masked, edge-detected IRQs.
// Optional WAIT_ACK timeout with sticky flag: define RAT_INTC_TIMEOUT_EN.
module rat_intr_ctrl
  import rat_intc_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter int         INTR_HOLD = 4,
  parameter int         HOLDOFF   = 4,
  parameter int         TIMEOUT   = 1024,
  parameter logic [7:0] MASK_ID   = MASK_ID_DEF,
  parameter logic [7:0] PEND_ID   = PEND_ID_DEF,
  parameter logic [7:0] VEC_ID    = VEC_ID_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_DATA,
  output logic             IN_HIT,
  output logic             INTR
);

  localparam int CNT_MAX = (INTR_HOLD > HOLDOFF) ? INTR_HOLD : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] active;
  logic             any_act;
  logic             wr_mask;
  logic             ack;
  logic             to_expire;
  logic             to_flag;

  intc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             intr_q, intr_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    rat_irq_edge_sync u_sync (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .irq_i  (IRQ[g]),
      .rise_o (rise[g])
    );
  end

  assign wr_mask = IO_STRB && (PORT_ID == MASK_ID);
  assign ack     = IO_STRB && (PORT_ID == PEND_ID);
  assign active  = pend_q & mask_q;
  assign any_act = |active;

  // New rises are OR-ed in after the W1C so a same-cycle set always survives.
  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    if (ack)     pend_d = pend_q & ~OUT_PORT[N_SRC-1:0];
    pend_d = pend_d | rise;
    if (wr_mask) mask_d = OUT_PORT[N_SRC-1:0];
  end

  // NOTE: every variable gets its default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    intr_d  = intr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_act) begin
          state_d = ST_ASSERT;
          intr_d  = 1'b1;
          cnt_d   = CNT_W'(INTR_HOLD - 1);
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_ACK;
          intr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          state_d = ST_HOLDOFF;
          cnt_d   = CNT_W'(HOLDOFF - 1);
        end else if (to_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intr_q  <= intr_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

`ifdef RAT_INTC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;

  // An ACK on the last WAIT_ACK cycle takes priority over the forced retry.
  assign to_expire = (state_q == ST_WAIT_ACK) && !ack && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d  = '0;
    to_flag_d = to_flag_q;
    if (state_q == ST_WAIT_ACK && !to_expire) to_cnt_d = to_cnt_q + 1'b1;
    if (to_expire)                 to_flag_d = 1'b1;
    else if (ack && OUT_PORT[7])   to_flag_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign to_flag = to_flag_q;
`else
  logic [31:0] unused_timeout;

  assign to_expire      = 1'b0;
  assign to_flag        = 1'b0;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  logic unused_wdata;
  assign unused_wdata = ^OUT_PORT;

  always_comb begin
    IN_DATA = '0;
    IN_HIT  = 1'b0;
    case (PORT_ID)
      MASK_ID: begin
        IN_HIT  = 1'b1;
        IN_DATA = 8'(mask_q);
      end
      PEND_ID: begin
        IN_HIT  = 1'b1;
        IN_DATA = 8'(pend_q);
      end
      VEC_ID: begin
        IN_HIT  = 1'b1;
        IN_DATA = {any_act, to_flag, 3'b000, lowest_set_idx(8'(active))};
      end
      default: ;
    endcase
  end

  assign INTR = intr_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl: directed scenarios plus randomized traffic
// compared against a latency/phase-level reference model.
module tb_rat_intr_ctrl;

  localparam int         N    = 4;
  localparam int         HOLD = 4;
  localparam int         HO   = 4;
  localparam int         TO   = 16;
  localparam logic [7:0] MID  = 8'h30;
  localparam logic [7:0] PID  = 8'h31;
  localparam logic [7:0] VID  = 8'h32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [N-1:0] IRQ;
  logic [7:0]   PORT_ID;
  logic [7:0]   OUT_PORT;
  logic         IO_STRB;
  logic [7:0]   IN_DATA;
  logic         IN_HIT;
  logic         INTR;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [N-1:0] m_pend, m_mask, cur_irq;
  logic [N-1:0] h1, h2, h3, h4;
  bit           m_intr, m_waiting, m_to;
  int           m_hi, m_ho, m_wc;

  rat_intr_ctrl #(
    .N_SRC     (N),
    .INTR_HOLD (HOLD),
    .HOLDOFF   (HO),
    .TIMEOUT   (TO)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IRQ      (IRQ),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .IN_DATA  (IN_DATA),
    .IN_HIT   (IN_HIT),
    .INTR     (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%02h expected=%02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0;
    h1 = '0; h2 = '0; h3 = '0; h4 = '0;
    m_intr = 0; m_waiting = 0; m_to = 0;
    m_hi = 0; m_ho = 0; m_wc = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] pid);
    logic [7:0] act = 8'(m_pend & m_mask);
    int idx = 0;
    bit found = 0;
    for (int i = 0; i < 8; i++) begin
      if (act[i] && !found) begin
        idx = i;
        found = 1;
      end
    end
    case (pid)
      MID:     return 8'(m_mask);
      PID:     return 8'(m_pend);
      VID:     return {found, m_to, 3'b000, 3'(idx)};
      default: return 8'h00;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_edge();
    bit           ack = IO_STRB && (PORT_ID == PID);
    bit           mw  = IO_STRB && (PORT_ID == MID);
    logic [N-1:0] rise = h3 & ~h4;
    bit           any_now = |(m_pend & m_mask);
`ifdef RAT_INTC_TIMEOUT_EN
    if (ack && OUT_PORT[7]) m_to = 0;
`endif
    if (m_hi > 0) begin
      m_hi--;
      if (m_hi == 0) begin
        m_intr = 0;
        m_waiting = 1;
        m_wc = 0;
      end
    end else if (m_waiting) begin
      if (ack) begin
        m_waiting = 0;
        m_ho = HO;
      end
`ifdef RAT_INTC_TIMEOUT_EN
      else begin
        m_wc++;
        if (m_wc == TO) begin
          m_waiting = 0;
          m_to = 1;
        end
      end
`endif
    end else if (m_ho > 0) begin
      m_ho--;
    end else if (any_now) begin
      m_intr = 1;
      m_hi = HOLD;
    end
    m_pend = (m_pend & ~(ack ? OUT_PORT[N-1:0] : '0)) | rise;
    if (mw) m_mask = OUT_PORT[N-1:0];
    h4 = h3; h3 = h2; h2 = h1; h1 = IRQ;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic [N-1:0] irq, input logic strb, input logic [7:0] pid,
                       input logic [7:0] wd);
    IRQ = irq; cur_irq = irq;
    IO_STRB = strb; PORT_ID = pid; OUT_PORT = wd;
    #1;
    check("rd_data", IN_DATA, m_read(pid));
    check("rd_hit", {7'd0, IN_HIT}, {7'd0, pid == MID || pid == PID || pid == VID});
    @(posedge CLK);
    model_edge();
    #1;
    check("intr", {7'd0, INTR}, {7'd0, m_intr});
    @(negedge CLK);
  endtask

  task automatic run_idle(input logic [7:0] pid, input int n, output int highs, output int rises);
    bit prev = INTR;
    highs = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      cycle(cur_irq, 1'b0, pid, 8'h00);
      if (INTR) highs++;
      if (INTR && !prev) rises++;
      prev = INTR;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    IRQ = '0; cur_irq = '0; IO_STRB = 1'b0; OUT_PORT = '0; PORT_ID = VID;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    int hi, ri;
    RESET = 1'b1;
    IRQ = '0; cur_irq = '0; IO_STRB = 1'b0; OUT_PORT = '0; PORT_ID = VID;
    model_reset();
    #1;
    check("rst_intr", {7'd0, INTR}, 8'h00);
    check("rst_vec", IN_DATA, 8'h00);
    check("rst_hit", {7'd0, IN_HIT}, 8'h01);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // 1: single source, pulse latency and width
    do_reset();
    cycle('0, 1'b1, MID, 8'h01);
    cycle(4'b0001, 1'b0, VID, 8'h00);
    run_idle(VID, 3, hi, ri);
    check("t1_vec", IN_DATA, 8'h80);
    check("t1_intr_low", {7'd0, INTR}, 8'h00);
    run_idle(VID, 12, hi, ri);
    check("t1_high_cycles", 8'(hi), 8'd4);
    check("t1_pulses", 8'(ri), 8'd1);

    // 2: two sources, W1C of the winner, re-pulse for the other
    do_reset();
    cycle('0, 1'b1, MID, 8'h0A);
    cycle(4'b1010, 1'b0, VID, 8'h00);
    run_idle(VID, 3, hi, ri);
    check("t2_vec", IN_DATA, 8'h81);
    run_idle(VID, 10, hi, ri);
    cycle(cur_irq, 1'b1, PID, 8'h02);
    cycle(cur_irq, 1'b0, VID, 8'h00);
    check("t2_vec_after_w1c", IN_DATA, 8'h83);
    run_idle(VID, 12, hi, ri);
    check("t2_repulse", 8'(ri), 8'd1);
    check("t2_repulse_len", 8'(hi), 8'd4);

    // 3: masked source stays pending, unmasking fires it
    do_reset();
    cycle('0, 1'b1, MID, 8'h00);
    cycle(4'b0100, 1'b0, PID, 8'h00);
    run_idle(PID, 5, hi, ri);
    check("t3_pend", IN_DATA, 8'h04);
    check("t3_no_intr", 8'(hi), 8'd0);
    cycle(cur_irq, 1'b1, MID, 8'h04);
    run_idle(VID, 10, hi, ri);
    check("t3_pulse", 8'(ri), 8'd1);
    check("t3_pulse_len", 8'(hi), 8'd4);

    // 4: two-cycle W1C strobe colliding with a new rise
    do_reset();
    cycle('0, 1'b0, PID, 8'h00);
    cycle(4'b0001, 1'b0, PID, 8'h00);
    cycle(cur_irq, 1'b0, PID, 8'h00);
    cycle(cur_irq, 1'b1, PID, 8'h01);
    cycle(cur_irq, 1'b1, PID, 8'h01);
    check("t4_set_wins", IN_DATA, 8'h01);
    cycle(cur_irq, 1'b0, PID, 8'h00);
    check("t4_still_pend", IN_DATA, 8'h01);

    // 5: asynchronous reset in the middle of a pulse
    do_reset();
    cycle('0, 1'b1, MID, 8'h01);
    cycle(4'b0001, 1'b0, VID, 8'h00);
    run_idle(VID, 4, hi, ri);
    check("t5_pre", {7'd0, INTR}, 8'h01);
    #2;
    RESET = 1'b1;
    #1;
    check("t5_intr_async", {7'd0, INTR}, 8'h00);
    IRQ = '0; cur_irq = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    cycle('0, 1'b0, MID, 8'h00);
    check("t5_mask", IN_DATA, 8'h00);
    cycle('0, 1'b0, PID, 8'h00);
    check("t5_pend", IN_DATA, 8'h00);
    cycle('0, 1'b0, VID, 8'h00);
    check("t5_vec", IN_DATA, 8'h00);

`ifdef RAT_INTC_TIMEOUT_EN
    // 6: no ACK -> forced retry and sticky timeout flag
    do_reset();
    cycle('0, 1'b1, MID, 8'h01);
    cycle(4'b0001, 1'b0, VID, 8'h00);
    run_idle(VID, 40, hi, ri);
    check("t6_retries", 8'(ri), 8'd2);
    check("t6_vec_to", IN_DATA, 8'hC0);
    cycle(cur_irq, 1'b1, PID, 8'h80);
    cycle(cur_irq, 1'b0, VID, 8'h00);
    check("t6_to_cleared", IN_DATA, 8'h80);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] irq_r = cur_irq;
      logic [7:0]   pid_r;
      int           sel = int'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) irq_r[$urandom_range(0, N - 1)] = ~irq_r[$urandom_range(0, N - 1)];
      case (sel)
        0:       pid_r = MID;
        1:       pid_r = PID;
        3:       pid_r = 8'($urandom);
        default: pid_r = VID;
      endcase
      cycle(irq_r, $urandom_range(0, 5) == 0, pid_r, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
